// File: rtl/multicycle_main_fsm_pkg.sv
// Shared constants for the multicycle RISC-V control path: opcodes, ALUOp codes,
// main-FSM state encodings and the bundled control word.
package multicycle_main_fsm_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    // Per-state control word; pc_update and branch never leave the FSM directly.
    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the main FSM (slave side) and the datapath (master side).
interface multicycle_main_fsm_if;

    logic [6:0] op;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;

    modport master (
        output op, zero,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src
    );

    modport slave (
        input  op, zero,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src
    );

endinterface

// File: rtl/multicycle_main_fsm_imm_src_decoder.sv
// Opcode -> immediate format select; shared with the pipelined core's decoder.
module imm_src_decoder
    import multicycle_main_fsm_pkg::*;
(
    input  logic [6:0] op_i,
    output logic [1:0] imm_src_o
);

    always_comb begin
        // NOTE: the default ahead of the case keeps every path assigned, so no latch is inferred.
        imm_src_o = IMM_I;
        case (op_i)
            OP_SW:   imm_src_o = IMM_S;
            OP_BEQ:  imm_src_o = IMM_B;
            OP_JAL:  imm_src_o = IMM_J;
            default: imm_src_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Moore main controller of the multicycle core: sequences Fetch/Decode/Execute/
// Memory/Writeback and drives datapath selects and write enables.
module multicycle_main_fsm
    import multicycle_main_fsm_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_main_fsm_if.slave bus
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        ctrl    = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.pc_update  = 1'b1;
                ctrl.alu_src_b  = 2'b10;
                ctrl.result_src = 2'b10;
                state_d         = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b01;
                state_d        = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                ctrl.adr_src = 1'b1;
                state_d      = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.result_src = 2'b01;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_op    = ALUOP_FUNCT;
                state_d        = S_ALUWB;
            end
            S_EXECUTEI: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALUOP_FUNCT;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.branch    = 1'b1;
            end
            S_JAL: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b10;
                ctrl.pc_update = 1'b1;
                state_d        = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset already parks the state in FETCH; the enables are masked so nothing commits meanwhile.
    assign bus.pc_write   = ~reset & (ctrl.pc_update | (ctrl.branch & bus.zero));
    assign bus.ir_write   = ~reset & ctrl.ir_write;
    assign bus.reg_write  = ~reset & ctrl.reg_write;
    assign bus.mem_write  = ~reset & ctrl.mem_write;
    assign bus.adr_src    = ctrl.adr_src;
    assign bus.result_src = ctrl.result_src;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.alu_op     = ctrl.alu_op;

    imm_src_decoder u_imm_src_decoder (
        .op_i      (bus.op),
        .imm_src_o (bus.imm_src)
    );

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: per-instruction step model compared every
// cycle, plus literal expectations for the key states of each instruction class.
module tb_multicycle_main_fsm;
    import multicycle_main_fsm_pkg::*;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] imm_src;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    int   k = 0;
    obs_t trace [0:7];

    always #5 clk = ~clk;

    multicycle_main_fsm_if bus ();

    multicycle_main_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic obs_t sample();
        obs_t s;
        s.pc_write   = bus.pc_write;
        s.adr_src    = bus.adr_src;
        s.mem_write  = bus.mem_write;
        s.ir_write   = bus.ir_write;
        s.reg_write  = bus.reg_write;
        s.result_src = bus.result_src;
        s.alu_src_a  = bus.alu_src_a;
        s.alu_src_b  = bus.alu_src_b;
        s.alu_op     = bus.alu_op;
        s.imm_src    = bus.imm_src;
        return s;
    endfunction

    function automatic int cpi(input logic [6:0] op);
        if (op == OP_LW) return 5;
        if (op == OP_SW || op == OP_R || op == OP_I || op == OP_JAL) return 4;
        if (op == OP_BEQ) return 3;
        return 2;
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        if (op == OP_SW)  return 2'b01;
        if (op == OP_BEQ) return 2'b10;
        if (op == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    // Expected outputs for step k of an instruction: 0 fetch, 1 decode, then class-specific steps.
    function automatic obs_t model(input logic [6:0] op, input int step, input logic z, input logic rst);
        obs_t e = '0;
        e.imm_src = imm_of(op);
        if (rst || step == 0) begin
            e.alu_src_b  = 2'b10;
            e.result_src = 2'b10;
            e.ir_write   = !rst;
            e.pc_write   = !rst;
            return e;
        end
        if (step == 1) begin
            e.alu_src_a = 2'b01;
            e.alu_src_b = 2'b01;
            return e;
        end
        if (op == OP_LW || op == OP_SW) begin
            if (step == 2) begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
            if (step == 3) begin e.adr_src = 1'b1; e.mem_write = (op == OP_SW); end
            if (step == 4) begin e.result_src = 2'b01; e.reg_write = 1'b1; end
        end else if (op == OP_R || op == OP_I) begin
            if (step == 2) begin
                e.alu_src_a = 2'b10;
                e.alu_src_b = (op == OP_I) ? 2'b01 : 2'b00;
                e.alu_op    = 2'b10;
            end
            if (step == 3) e.reg_write = 1'b1;
        end else if (op == OP_JAL) begin
            if (step == 2) begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1; end
            if (step == 3) e.reg_write = 1'b1;
        end else if (op == OP_BEQ) begin
            e.alu_src_a = 2'b10;
            e.alu_op    = 2'b01;
            e.pc_write  = z;
        end
        return e;
    endfunction

    // Step counter within the current instruction; op is stable whenever this advances past step 0.
    always @(posedge clk or posedge reset) begin
        if (reset) k <= 0;
        else       k <= (k + 1 >= cpi(bus.op)) ? 0 : k + 1;
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            check($sformatf("cycle op=%b step=%0d", bus.op, k), 32'(sample()),
                  32'(model(bus.op, k, bus.zero, reset)));
        end
    end

    // Runs one instruction starting at a negedge in its fetch step; leaves the bench at the next fetch.
    task automatic run(input logic [6:0] o, input logic z, input bit glitch);
        bus.op   = o;
        bus.zero = z;
        for (int c = 0; c < cpi(o); c++) begin
            #3 trace[c] = sample();
            @(negedge clk);
            if (glitch && o != OP_BEQ) bus.zero = ~bus.zero;
        end
    endtask

    initial begin
        obs_t s;
        reset    = 1'b1;
        bus.op   = OP_LW;
        bus.zero = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run(OP_LW, 1'b0, 1'b0);
        check("lw_memadr_adr", 32'(trace[2].adr_src), 32'd0);
        check("lw_memread_adr", 32'(trace[3].adr_src), 32'd1);
        check("lw_memwb", 32'({trace[4].reg_write, trace[4].result_src}), 32'b101);
        check("lw_back_to_fetch", 32'(bus.ir_write), 32'd1);

        // Reset in the middle of MEMREAD, held over two edges, then released.
        bus.op = OP_LW;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        #2 s = sample();
        check("rst_enables", 32'({s.pc_write, s.ir_write, s.reg_write, s.mem_write}), 32'd0);
        check("rst_selects", 32'({s.alu_src_b, s.result_src, s.adr_src}), 32'b10_10_0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        #2 s = sample();
        check("rel_first_fetch", 32'({s.ir_write, s.pc_write}), 32'b11);
        repeat (5) @(negedge clk);

        run(OP_SW, 1'b0, 1'b0);
        check("sw_memwrite", 32'({trace[3].mem_write, trace[3].adr_src}), 32'b11);
        check("sw_imm", 32'({trace[0].imm_src, trace[2].imm_src, trace[3].imm_src}), 32'b01_01_01);
        check("sw_no_regwrite", 32'({trace[1].reg_write, trace[2].reg_write, trace[3].reg_write}), 32'd0);

        run(OP_BEQ, 1'b1, 1'b0);
        check("beq_taken", 32'({trace[2].alu_op, trace[2].pc_write}), 32'b01_1);
        run(OP_BEQ, 1'b0, 1'b0);
        check("beq_not_taken", 32'({trace[2].alu_op, trace[2].pc_write}), 32'b01_0);
        check("beq_cpi", 32'(bus.ir_write), 32'd1);

        run(OP_JAL, 1'b0, 1'b1);
        check("jal_state", 32'({trace[2].pc_write, trace[2].alu_src_a, trace[2].alu_src_b}), 32'b1_01_10);
        check("jal_aluwb", 32'(trace[3].reg_write), 32'd1);
        check("jal_imm", 32'(trace[1].imm_src), 32'b11);

        run(OP_R, 1'b1, 1'b1);
        check("r_execute", 32'({trace[2].alu_op, trace[2].alu_src_a, trace[2].alu_src_b}), 32'b10_10_00);
        check("r_aluwb", 32'(trace[3].reg_write), 32'd1);

        run(7'b1111111, 1'b0, 1'b1);
        check("nop_decode", 32'({trace[1].reg_write, trace[1].mem_write, trace[1].pc_write}), 32'd0);
        check("nop_refetch", 32'(bus.ir_write), 32'd1);

        run(OP_I, 1'b0, 1'b1);
        check("i_execute", 32'({trace[2].alu_op, trace[2].alu_src_b}), 32'b10_01);

        run(OP_LW, 1'b1, 1'b1);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multicycle_main_fsm.md
# multicycle_main_fsm

Main control state machine for the multicycle RISC-V core. Consumes the opcode from the instruction register and the ALU zero flag, and steps each instruction through Fetch/Decode/Execute/Memory/Writeback. Drives the datapath mux selects, the write enables and the 2-bit ALUOp that the ALU decoder expands into the 3-bit ALU control. Supported instructions: lw, sw, R-type, I-type ALU, beq, jal.

## Interface
Parameters: none. Opcode and state encodings are fixed constants.
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces state to FETCH
- op  in  7  instr[6:0] from the instruction register
- zero  in  1  ALU zero flag, sampled combinationally in BEQ
- pc_write  out  1  PC register enable = pc_update | (branch & zero)
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register
- mem_write  out  1  data memory write enable
- ir_write  out  1  instruction register and old-PC register enable
- result_src  out  2  result mux select: 00 ALUOut, 01 data, 10 ALU result
- alu_src_a  out  2  ALU A select: 00 PC, 01 old PC, 10 rs1 register
- alu_src_b  out  2  ALU B select: 00 rs2 register, 01 immediate, 10 constant 4
- alu_op  out  2  to ALU decoder: 00 add, 01 subtract, 10 decode funct3/funct7
- reg_write  out  1  register file write enable
- imm_src  out  2  immediate format: 00 I, 01 S, 10 B, 11 J

## Operation
- Moore FSM with 11 states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: lw (0000011) or sw (0100011) -> MEMADR; R (0110011) -> EXECUTER; I (0010011) -> EXECUTEI; jal (1101111) -> JAL; beq (1100011) -> BEQ; any other op -> FETCH (executes as a NOP, no side effects).
  - MEMADR: op == lw -> MEMREAD, otherwise MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH. MEMWRITE -> FETCH.
  - EXECUTER, EXECUTEI and JAL -> ALUWB -> FETCH. BEQ -> FETCH.
- Per-state outputs. Any signal not listed is 0 / 00.
  - FETCH: ir_write=1, pc_update=1, alu_src_b=10, result_src=10.
  - DECODE: alu_src_a=01, alu_src_b=01 (branch/jump target precompute).
  - MEMADR: alu_src_a=10, alu_src_b=01.
  - MEMREAD: adr_src=1.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: adr_src=1, mem_write=1.
  - EXECUTER: alu_src_a=10, alu_op=10.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10.
  - ALUWB: reg_write=1.
  - BEQ: alu_src_a=10, alu_op=01, branch=1.
  - JAL: alu_src_a=01, alu_src_b=10, pc_update=1.
- imm_src is decoded combinationally from op, independent of state: lw/I -> 00, sw -> 01, beq -> 10, jal -> 11, others -> 00.
- pc_update and branch are internal signals. zero is used only through pc_write in BEQ.

## Timing
- CPI: lw 5; sw, R, I, jal 4; beq 3; unsupported op 2.
- All outputs except pc_write and imm_src are functions of the current state only; there is no combinational path from op to them.
- The next-state decision in DECODE and MEMADR uses op as seen in that cycle. op is stable from the cycle after FETCH until the next FETCH.
- Reset:
  - Asserting reset at any time, including mid-instruction, moves the state to FETCH immediately (asynchronously).
  - While reset is high, pc_write, ir_write, reg_write and mem_write are forced to 0. Mux selects and alu_op show the FETCH values.
  - The first rising edge after reset deasserts performs a normal FETCH.
- A glitch on zero outside BEQ has no effect on pc_write.

## Structure
- Add to the shared constants file: opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ), the 4-bit state encodings, and ALUOp codes (ALUOP_ADD 00, ALUOP_SUB 01, ALUOP_FUNCT 10). The ALU decoder uses the same ALUOp codes.
- Split into one state register block and one output-decode block.
- One sub-module, imm_src_decoder, for the op -> imm_src mapping; the instruction decoder of the pipelined core reuses it.

## Test plan
- Reset mid-MEMREAD, then release -> state is FETCH during reset with all four enables 0; the first cycle after release has ir_write=1, pc_write=1.
- op=0000011 (lw) -> 5 cycles FETCH, DECODE, MEMADR, MEMREAD, MEMWB; adr_src=1 only in MEMREAD; reg_write=1 only in MEMWB with result_src=01.
- op=0100011 (sw) -> 4 cycles ending in MEMWRITE with mem_write=1 and adr_src=1; imm_src=01 throughout; reg_write never asserted.
- op=1100011 (beq), run once with zero=1 and once with zero=0 -> 3 cycles; in BEQ, alu_op=01, and pc_write equals zero.
- op=1101111 (jal) -> JAL state has pc_write=1, alu_src_a=01, alu_src_b=10; next cycle is ALUWB with reg_write=1; imm_src=11.
- op=0110011 (R) then op=1111111 (unsupported) -> R takes 4 cycles with alu_op=10 in EXECUTER; the unsupported op returns to FETCH after DECODE with no reg_write or mem_write.
